// File: rtl/watchdog_window_pkg.sv
// Shared types for the windowed watchdog: FSM states and the sticky reset cause.
package watchdog_window_pkg;

  // Watchdog operating states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIRE = 2'd2
  } state_e;

  // Reason for the most recent system reset request (sticky until cleared).
  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_TIMEOUT = 2'd1,
    CAUSE_EARLY   = 2'd2
  } cause_e;

endpackage

// File: rtl/watchdog_window_if.sv
// Control/status bundle between the SoC and the windowed watchdog.
// The master side programs thresholds and kicks; the slave side is the watchdog.
interface watchdog_window_if #(
  parameter int CNT_W = 32
);

  logic             en_i;       // watchdog enable
  logic             kick_i;     // service pulse, level sampled every cycle
  logic             clr_i;      // clear sticky cause
  logic [CNT_W-1:0] timeout_i;  // timeout threshold T, 0 = never time out
  logic [CNT_W-1:0] window_i;   // earliest legal kick count W, 0 = no window
  logic [CNT_W-1:0] warn_i;     // warning threshold A, 0 = no warning

  logic             warn_o;     // count reached warning threshold
  logic             early_o;    // one-cycle pulse after an early kick
  logic             sys_rst_o;  // system reset request
  logic [1:0]       cause_o;    // sticky reset cause
  logic [CNT_W-1:0] cnt_o;      // current count

  modport master (
    output en_i, kick_i, clr_i, timeout_i, window_i, warn_i,
    input  warn_o, early_o, sys_rst_o, cause_o, cnt_o
  );

  modport slave (
    input  en_i, kick_i, clr_i, timeout_i, window_i, warn_i,
    output warn_o, early_o, sys_rst_o, cause_o, cnt_o
  );

endinterface

// File: rtl/watchdog_rst_stretch.sv
// Turns a single-cycle trigger into a reset pulse exactly RST_PULSE cycles long.
// done_o marks the last high cycle so the owner can leave its FIRE state in step
// with the pulse falling.
module watchdog_rst_stretch #(
  parameter int RST_PULSE = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic trig_i,
  output logic pulse_o,
  output logic done_o
);

  localparam int CW = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;

  logic [CW-1:0] left_q;  // high cycles remaining after the current one

  // Pulse register and down-counter; a trigger (re)starts the full pulse.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state is always updated with non-blocking assignments so
    // every register samples pre-edge values regardless of statement order.
    if (rst_i) begin
      pulse_o <= 1'b0;
      left_q  <= '0;
    end else if (trig_i) begin
      pulse_o <= 1'b1;
      left_q  <= CW'(RST_PULSE - 1);
    end else if (pulse_o) begin
      if (left_q == '0) begin
        pulse_o <= 1'b0;
      end else begin
        left_q <= left_q - CW'(1);
      end
    end
  end

  assign done_o = pulse_o && (left_q == '0);

endmodule

// File: rtl/watchdog_window.sv
// Windowed watchdog. Counts cycles since the last legal kick and requests a
// stretched system reset on timeout or, when EARLY_IS_FATAL, on a kick that
// arrives before the window opens. Thresholds are shadowed when the counter
// (re)starts so software may reprogram them at any time without glitches.
module watchdog_window
  import watchdog_window_pkg::*;
#(
  parameter int CNT_W          = 32,
  parameter int RST_PULSE      = 16,
  parameter int EARLY_IS_FATAL = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  watchdog_window_if.slave bus
);

  // Registered state
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] t_q, w_q, a_q;     // shadowed timeout / window / warning
  logic             warn_q, warn_d;
  logic             early_q, early_d;
  cause_e           cause_q, cause_d;

  // Combinational controls
  logic             load_shadow;
  logic             fire_trig;
  logic             fire_done;
  logic             sys_rst;
  cause_e           fire_cause;
  logic             legal_kick;
  logic             early_kick;
  logic [CNT_W-1:0] cnt_inc;

  // A kick is legal once the count has reached the window; W=0 makes every kick legal.
  assign legal_kick = bus.kick_i && (cnt_q >= w_q);
  assign early_kick = bus.kick_i && !legal_kick;
  assign cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  // Next-state, counter, flag and cause decoding.
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    warn_d      = 1'b0;
    early_d     = 1'b0;
    cause_d     = cause_q;
    load_shadow = 1'b0;
    fire_trig   = 1'b0;
    fire_cause  = CAUSE_NONE;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.en_i) begin
          state_d     = RUN;
          load_shadow = 1'b1;
        end
      end

      RUN: begin
        early_d = early_kick;
        // Disabling wins over everything: a switched-off watchdog never fires.
        if (!bus.en_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (early_kick && (EARLY_IS_FATAL != 0)) begin
          state_d    = FIRE;
          cnt_d      = '0;
          fire_trig  = 1'b1;
          fire_cause = CAUSE_EARLY;
        end else if (!legal_kick && (t_q != '0) && (cnt_q == t_q - CNT_W'(1))) begin
          state_d    = FIRE;
          cnt_d      = '0;
          fire_trig  = 1'b1;
          fire_cause = CAUSE_TIMEOUT;
        end else if (legal_kick) begin
          cnt_d       = '0;
          load_shadow = 1'b1;
        end else begin
          cnt_d  = cnt_inc;
          warn_d = (a_q != '0) && (a_q < t_q) && (cnt_q >= a_q);
        end
      end

      FIRE: begin
        // Kicks and enable are ignored until the reset pulse has completed.
        cnt_d = '0;
        if (fire_done) begin
          if (bus.en_i) begin
            state_d     = RUN;
            load_shadow = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // A new cause beats a simultaneous clear.
    if (fire_trig) begin
      cause_d = fire_cause;
    end else if (bus.clr_i) begin
      cause_d = CAUSE_NONE;
    end
  end

  // State, counter and output flag registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      warn_q  <= 1'b0;
      early_q <= 1'b0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      warn_q  <= warn_d;
      early_q <= early_d;
      cause_q <= cause_d;
    end
  end

  // Threshold shadows, captured whenever the counter restarts in RUN.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      t_q <= '0;
      w_q <= '0;
      a_q <= '0;
    end else if (load_shadow) begin
      t_q <= bus.timeout_i;
      w_q <= bus.window_i;
      a_q <= bus.warn_i;
    end
  end

  watchdog_rst_stretch #(
    .RST_PULSE (RST_PULSE)
  ) u_stretch (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .trig_i  (fire_trig),
    .pulse_o (sys_rst),
    .done_o  (fire_done)
  );

  assign bus.warn_o    = warn_q;
  assign bus.early_o   = early_q;
  assign bus.sys_rst_o = sys_rst;
  assign bus.cause_o   = cause_q;
  assign bus.cnt_o     = cnt_q;

endmodule
